full_jacobian_driver: RTL and testbench

Control-and-arithmetic partner for the full Jacobian datapath. It sequences a Jacobian run by driving the datapath's enable, reset and step counter through a fixed schedule. It also serves the datapath's shared multiplier requests: 9 array lanes and a 6x6 matrix bank, pipelined, with fixed-point scaling and saturation. It sits between the top-level IK controller (start/done) and the full Jacobian block, and answers that block's multiplier operand outputs with result inputs.

---
 rtl/ik_pkg.sv | 23 ++
 rtl/sat_mult_pipe.sv | 48 ++++
 rtl/full_jacobian_driver.sv | 120 ++++++++++++
 tb/tb_full_jacobian_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ik_pkg.sv
// Shared types and constants for the IK Jacobian block: operand words,
// lane counts, fixed-point formats, multiplier latency and FSM states.
package ik_pkg;

  typedef logic signed [26:0] arr_word_t;
  typedef logic signed [35:0] mat_word_t;

  localparam int unsigned ARR_LANES = 9;
  localparam int unsigned MAT_DIM   = 6;
  localparam int unsigned ARR_W     = 27;
  localparam int unsigned MAT_W     = 36;
  localparam int unsigned ARR_FRAC  = 16;
  localparam int unsigned MAT_FRAC  = 24;
  localparam int unsigned MULT_LAT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sat_mult_pipe.sv
// Two-stage signed fixed-point multiplier: registers the operands, then
// registers the floor-shifted product clamped to the W-bit signed range.
module sat_mult_pipe #(
  parameter int unsigned W    = 27,
  parameter int unsigned FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] result
);

  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0]   a_q, b_q;
  logic signed [2*W-1:0] a_ext, b_ext, prod, shifted;
  logic signed [W-1:0]   res_d, res_q;

  always_comb begin
    a_ext   = a_q;
    b_ext   = b_q;
    prod    = a_ext * b_ext;
    shifted = prod >>> FRAC;
    res_d   = shifted[W-1:0];
    if (shifted > SAT_MAX) begin
      res_d = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      res_d = SAT_MIN[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/full_jacobian_driver.sv
// Run sequencer for the full Jacobian datapath plus its shared pipelined
// saturating multipliers (9 array lanes, 6x6 matrix lanes).
module full_jacobian_driver
  import ik_pkg::*;
#(
  parameter logic [7:0] LAST_COUNT = 8'd200
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  jac_rst,
  output logic                                  jac_en,
  output logic [7:0]                            jac_count,
  input  arr_word_t [ARR_LANES-1:0]             array_mult_dataa,
  input  arr_word_t [ARR_LANES-1:0]             array_mult_datab,
  output arr_word_t [ARR_LANES-1:0]             array_mult_result,
  input  mat_word_t [MAT_DIM-1:0][MAT_DIM-1:0]  mat_mult_dataa,
  input  mat_word_t [MAT_DIM-1:0][MAT_DIM-1:0]  mat_mult_datab,
  output mat_word_t [MAT_DIM-1:0][MAT_DIM-1:0]  mat_mult_result
);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       jac_rst_q, jac_rst_d;
  logic       jac_en_q, jac_en_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          count_d = '0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        count_d = '0;
      end
      ST_RUN: begin
        // Holding at LAST_COUNT keeps the index from wrapping when it is 255.
        if (count_q == LAST_COUNT) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs decoded from the next state so they leave straight from flops.
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    jac_rst_d = (state_d == ST_CLEAR);
    jac_en_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      jac_rst_q <= 1'b0;
      jac_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      jac_rst_q <= jac_rst_d;
      jac_en_q  <= jac_en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign jac_rst   = jac_rst_q;
  assign jac_en    = jac_en_q;
  assign jac_count = count_q;

  for (genvar i = 0; i < ARR_LANES; i++) begin : g_arr
    sat_mult_pipe #(
      .W    (ARR_W),
      .FRAC (ARR_FRAC)
    ) u_mult (
      .clk    (clk),
      .rst    (rst),
      .a      (array_mult_dataa[i]),
      .b      (array_mult_datab[i]),
      .result (array_mult_result[i])
    );
  end

  for (genvar r = 0; r < MAT_DIM; r++) begin : g_mat_row
    for (genvar c = 0; c < MAT_DIM; c++) begin : g_mat_col
      sat_mult_pipe #(
        .W    (MAT_W),
        .FRAC (MAT_FRAC)
      ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .a      (mat_mult_dataa[r][c]),
        .b      (mat_mult_datab[r][c]),
        .result (mat_mult_result[r][c])
      );
    end
  end

endmodule

// File: tb/tb_full_jacobian_driver.sv
// Scoreboard bench for full_jacobian_driver: stimulus queues expected
// FSM outputs and multiplier results per cycle, a monitor compares them.
module tb_full_jacobian_driver;
  import ik_pkg::*;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, jac_rst, jac_en;
  logic [7:0] jac_count;
  arr_word_t [ARR_LANES-1:0] arr_a, arr_b, arr_res;
  mat_word_t [MAT_DIM-1:0][MAT_DIM-1:0] mat_a, mat_b, mat_res;

  always #5 clk = ~clk;

  full_jacobian_driver #(.LAST_COUNT(8'd4)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .jac_rst           (jac_rst),
    .jac_en            (jac_en),
    .jac_count         (jac_count),
    .array_mult_dataa  (arr_a),
    .array_mult_datab  (arr_b),
    .array_mult_result (arr_res),
    .mat_mult_dataa    (mat_a),
    .mat_mult_datab    (mat_b),
    .mat_mult_result   (mat_res)
  );

  typedef struct {
    int         cyc;
    logic [3:0] flags;   // {busy, jac_rst, jac_en, done}
    logic [7:0] count;
    bit         chk_cnt;
  } fsm_exp_t;

  typedef struct {
    int               cyc;
    bit               is_mat;
    int               i;
    int               j;
    logic signed [35:0] val;
  } mult_exp_t;

  fsm_exp_t  fsm_q[$];
  mult_exp_t mult_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fsm(input int c, input logic b, input logic r, input logic e,
                          input logic d, input logic [7:0] cnt, input bit chk);
    fsm_exp_t x;
    x.cyc = c; x.flags = {b, r, e, d}; x.count = cnt; x.chk_cnt = chk;
    fsm_q.push_back(x);
  endtask

  task automatic push_mult(input int c, input bit m, input int i, input int j,
                           input logic signed [35:0] v);
    mult_exp_t x;
    x.cyc = c; x.is_mat = m; x.i = i; x.j = j; x.val = v;
    mult_q.push_back(x);
  endtask

  // Full run with LAST_COUNT=4 whose CLEAR cycle is at cycle base.
  task automatic push_run(input int base);
    push_fsm(base, 1, 1, 0, 0, 8'd0, 1);
    for (int k = 0; k < 5; k++) push_fsm(base + 1 + k, 1, 0, 1, 0, 8'(k), 1);
    push_fsm(base + 6, 1, 0, 0, 1, 8'd4, 1);
    push_fsm(base + 7, 0, 0, 0, 0, 8'd0, 0);
  endtask

  // Monitor: compare every expectation due at this cycle.
  initial begin
    fsm_exp_t  f;
    mult_exp_t m;
    logic signed [35:0] act;
    forever begin
      @(negedge clk);
      while (fsm_q.size() > 0 && fsm_q[0].cyc <= cyc) begin
        f = fsm_q.pop_front();
        if (f.cyc < cyc) begin
          check("fsm_stale", 64'(f.cyc), 64'(cyc));
        end else begin
          check("fsm_flags", 64'({busy, jac_rst, jac_en, done}), 64'(f.flags));
          if (f.chk_cnt) check("jac_count", 64'(jac_count), 64'(f.count));
        end
      end
      while (mult_q.size() > 0 && mult_q[0].cyc <= cyc) begin
        m = mult_q.pop_front();
        if (m.cyc < cyc) begin
          check("mult_stale", 64'(m.cyc), 64'(cyc));
        end else begin
          if (m.is_mat) act = mat_res[m.i][m.j];
          else act = arr_res[m.i];
          check(m.is_mat ? $sformatf("mat[%0d][%0d]", m.i, m.j) : $sformatf("arr[%0d]", m.i),
                64'(act), 64'(m.val));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    arr_a = '0; arr_b = '0; mat_a = '0; mat_b = '0;
    tick(); tick();
    // Reset state.
    push_fsm(cyc, 0, 0, 0, 0, 8'd0, 1);
    push_mult(cyc, 0, 0, 0, 36'sd0);
    push_mult(cyc, 1, 5, 5, 36'sd0);
    rst = 1'b0;
    tick();

    // Single start pulse.
    n = cyc;
    start = 1'b1;
    push_run(n + 1);
    tick();
    start = 1'b0;
    repeat (9) tick();

    // Array lanes: back-to-back operands, saturation, flooring.
    n = cyc;
    arr_a[0] = 27'sh18000;   arr_b[0] = 27'sh20000;
    arr_a[8] = -27'sh18000;  arr_b[8] = 27'sh20000;
    push_mult(n + MULT_LAT, 0, 0, 0, 36'sh30000);
    push_mult(n + MULT_LAT, 0, 8, 0, -36'sh30000);
    push_mult(n + MULT_LAT, 0, 1, 0, 36'sd0);
    tick();
    arr_a[0] = 27'sh2000000; arr_b[0] = 27'sh40000;
    push_mult(n + 1 + MULT_LAT, 0, 0, 0, 36'sh3FFFFFF);
    tick();
    arr_a[0] = -27'sh2000000; arr_b[0] = 27'sh40000;
    push_mult(n + 2 + MULT_LAT, 0, 0, 0, -36'sh4000000);
    tick();
    arr_a[0] = -27'sd1; arr_b[0] = 27'sd1;
    push_mult(n + 3 + MULT_LAT, 0, 0, 0, -36'sd1);
    tick();
    arr_a = '0; arr_b = '0;
    push_mult(n + 4 + MULT_LAT, 0, 0, 0, 36'sd0);
    repeat (4) tick();

    // Matrix lanes: unity, neighbour isolation, saturation.
    n = cyc;
    mat_a[5][5] = 36'sh1000000;  mat_b[5][5] = 36'sh1000000;
    mat_a[0][3] = 36'sh3000000;  mat_b[0][3] = -36'sh800000;
    mat_a[2][2] = 36'sh400000000; mat_b[2][2] = 36'sh4000000;
    push_mult(n + 2, 1, 5, 5, 36'sh1000000);
    push_mult(n + 2, 1, 0, 3, -36'sh1800000);
    push_mult(n + 2, 1, 0, 2, 36'sd0);
    push_mult(n + 2, 1, 0, 4, 36'sd0);
    push_mult(n + 2, 1, 1, 3, 36'sd0);
    push_mult(n + 2, 1, 2, 2, 36'sh7FFFFFFFF);
    tick();
    mat_a = '0; mat_b = '0;
    push_mult(n + 3, 1, 5, 5, 36'sd0);
    repeat (4) tick();

    // Start held high: no retrigger until IDLE, then relaunch.
    n = cyc;
    start = 1'b1;
    push_run(n + 1);
    push_run(n + 9);
    while (cyc < n + 9) tick();
    start = 1'b0;
    repeat (9) tick();

    // Reset mid-run at jac_count==2.
    n = cyc;
    start = 1'b1;
    push_fsm(n + 1, 1, 1, 0, 0, 8'd0, 1);
    push_fsm(n + 2, 1, 0, 1, 0, 8'd0, 1);
    push_fsm(n + 3, 1, 0, 1, 0, 8'd1, 1);
    push_fsm(n + 4, 1, 0, 1, 0, 8'd2, 1);
    for (int k = 5; k < 13; k++) push_fsm(n + k, 0, 0, 0, 0, 8'd0, 1);
    tick();
    start = 1'b0;
    tick();
    arr_a[0] = 27'sh10000; arr_b[0] = 27'sh10000;
    push_mult(n + 4, 0, 0, 0, 36'sh10000);
    push_mult(n + 5, 0, 0, 0, 36'sd0);
    push_mult(n + 6, 0, 0, 0, 36'sd0);
    push_mult(n + 7, 0, 0, 0, 36'sh10000);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();

    for (int k = 0; k < 50 && (fsm_q.size() + mult_q.size()) > 0; k++) tick();
    check("drain", 64'(fsm_q.size() + mult_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
